// File: rtl/dist_disp_pkg.sv
// Shared constants, types and seven-segment glyphs for the distance display path.
// Glyphs are stored high-true (bit0=a .. bit6=g, bit7=dp); polarity is applied at the pins.
package dist_disp_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int DIST_W     = 10;
  localparam int DIST_MAX   = 999;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_t;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  function automatic logic [7:0] seg_glyph(input bcd_digit_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/dist_display_mux_if.sv
// Distance-in / display-out bundle: the ranging stage drives distance, the display block drives pins.
interface dist_display_mux_if;
  import dist_disp_pkg::*;

  logic [DIST_W-1:0]     distance;
  logic                  dist_valid;
  logic                  busy;
  logic [7:0]            ss;
  logic [NUM_DIGITS-1:0] en;

  modport master (output distance, dist_valid, input busy, ss, en);
  modport slave  (input distance, dist_valid, output busy, ss, en);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one bit per clock, values above DIST_MAX skip straight to COMMIT
// with the overflow flag set. o_done is high for the single COMMIT cycle.
module bin2bcd_seq
  import dist_disp_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_start,
  input  logic [DIST_W-1:0]                  i_bin,
  output logic                               o_busy,
  output logic                               o_done,
  output bcd_digit_t [NUM_DIGITS-1:0]        o_bcd,
  output logic                               o_ovf
);

  localparam logic [3:0] ITER_LAST = 4'(DIST_W - 1);

  conv_state_t                 r_state;
  conv_state_t                 w_next;
  logic [DIST_W-1:0]           r_shift;
  bcd_digit_t [NUM_DIGITS-1:0] r_bcd;
  bcd_digit_t [NUM_DIGITS-1:0] w_adj;
  logic [3:0]                  r_iter;
  logic                        r_ovf;

  // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the order.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_next = (i_bin > DIST_W'(DIST_MAX)) ? ST_COMMIT : ST_SHIFT;
      ST_SHIFT:  if (r_iter == ITER_LAST) w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != ST_IDLE);
    o_done = (r_state == ST_COMMIT);
  end

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[i] >= 4'd5) w_adj[i] = r_bcd[i] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_iter  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_shift <= i_bin;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_ovf   <= (i_bin > DIST_W'(DIST_MAX));
          end
        end
        ST_SHIFT: begin
          {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
          r_iter           <= r_iter + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_bcd = r_bcd;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/dist_display_mux.sv
// Distance to 3-digit multiplexed seven-segment display: converter, refresh counter, digit mux.
// Optional LEAD_ZERO_BLANK_EN blanks leading zeros in the hundreds and tens positions.
module dist_display_mux
  import dist_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 4000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit EN_ACTIVE_LOW  = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  dist_display_mux_if.slave bus
);

  localparam int                 CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [7:0]         SS_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] EN_OFF = EN_ACTIVE_LOW ? '1 : '0;

  logic                        w_busy;
  logic                        w_done;
  bcd_digit_t [NUM_DIGITS-1:0] w_bcd;
  logic                        w_ovf;

  bcd_digit_t [NUM_DIGITS-1:0] r_disp;
  logic                        r_disp_ovf;
  logic [CNT_W-1:0]            r_cnt;
  logic [1:0]                  r_idx;
  logic [7:0]                  r_ss;
  logic [NUM_DIGITS-1:0]       r_en;

  bcd_digit_t                  w_digit;
  logic [7:0]                  w_glyph;
  logic [7:0]                  w_ss_ht;
  logic [NUM_DIGITS-1:0]       w_en_ht;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (bus.dist_valid),
    .i_bin   (bus.distance),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd),
    .o_ovf   (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp     <= '0;
      r_disp_ovf <= 1'b0;
    end else if (w_done) begin
      r_disp     <= w_bcd;
      r_disp_ovf <= w_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_digit = r_disp[0];
    case (r_idx)
      2'd1:    w_digit = r_disp[1];
      2'd2:    w_digit = r_disp[2];
      default: ;
    endcase
    w_glyph = seg_glyph(w_digit);
`ifdef LEAD_ZERO_BLANK_EN
    if (r_idx == 2'd2 && r_disp[2] == 4'd0) w_glyph = SEG_BLANK;
    if (r_idx == 2'd1 && r_disp[2] == 4'd0 && r_disp[1] == 4'd0) w_glyph = SEG_BLANK;
`endif
    if (r_disp_ovf) w_glyph = SEG_DASH;

    // Count 0 of every slot is a blanking clock to hide ghosting between digits.
    w_en_ht = '0;
    w_ss_ht = SEG_BLANK;
    if (r_cnt != '0) begin
      w_en_ht = NUM_DIGITS'(1) << r_idx;
      w_ss_ht = w_glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ss <= SS_OFF;
      r_en <= EN_OFF;
    end else begin
      r_ss <= SEG_ACTIVE_LOW ? ~w_ss_ht : w_ss_ht;
      r_en <= EN_ACTIVE_LOW  ? ~w_en_ht : w_en_ht;
    end
  end

  assign bus.busy = w_busy;
  assign bus.ss   = r_ss;
  assign bus.en   = r_en;

endmodule
